// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: reset vector default, redirect
// source indices and the controller state encoding.
package fetch_pkg;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hbfc00000;

  localparam int unsigned REDIR_EXC  = 0;
  localparam int unsigned REDIR_ERET = 1;
  localparam int unsigned REDIR_BR   = 2;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch request channel between the PC unit (master) and instruction
// memory (slave): valid/ready handshake plus request attributes.
interface fetch_pc_unit_if #(
  parameter int unsigned PC_W = 32
);

  logic            fetch_valid;
  logic            fetch_ready;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_stale;
  logic            fetch_adel;
  logic            fetch_pred_tk;

  modport master (
    output fetch_valid, fetch_pc, fetch_stale, fetch_adel, fetch_pred_tk,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_stale, fetch_adel, fetch_pred_tk,
    output fetch_ready
  );

endinterface

// File: rtl/fetch_pc_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the current
// fetch PC, write/invalidate at the clock edge.
module fetch_btb #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic [PC_W-1:0] target,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = PC_W - 2 - IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [PC_W-1:0]  tgt_q [DEPTH];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lsb_unused;

  assign lk_idx     = lookup_pc[2 +: IDX_W];
  assign lk_tag     = lookup_pc[PC_W-1 -: TAG_W];
  assign up_idx     = upd_pc[2 +: IDX_W];
  assign up_tag     = upd_pc[PC_W-1 -: TAG_W];
  assign lsb_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign target = tgt_q[lk_idx];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
      end else if (valid_q[up_idx] && (tag_q[up_idx] == up_tag)) begin
        valid_q[up_idx] <= 1'b0;
      end
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: prioritised redirects, pending-redirect latch under
// backpressure, sequential step. Optional BTB via FETCH_PC_BTB_EN.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF),
  parameter int unsigned     NUM_REDIR    = 3,
  parameter int unsigned     INCR         = 4,
  parameter int unsigned     BTB_DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*PC_W-1:0] redir_pc,
  fetch_pc_unit_if.master           fif,
  input  logic                      btb_upd_valid,
  input  logic [PC_W-1:0]           btb_upd_pc,
  input  logic [PC_W-1:0]           btb_upd_target,
  input  logic                      btb_upd_taken
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;

  logic            redir_any;
  logic [PC_W-1:0] redir_tgt;
  logic            valid, hs;
  logic            btb_hit;
  logic [PC_W-1:0] btb_tgt, seq_pc;

`ifdef FETCH_PC_BTB_EN
  fetch_btb #(
    .PC_W  (PC_W),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk        (clk),
    .resetn     (resetn),
    .lookup_pc  (pc_q),
    .hit        (btb_hit),
    .target     (btb_tgt),
    .upd_valid  (btb_upd_valid),
    .upd_pc     (btb_upd_pc),
    .upd_target (btb_upd_target),
    .upd_taken  (btb_upd_taken)
  );
`else
  logic btb_unused;
  assign btb_hit    = 1'b0;
  assign btb_tgt    = '0;
  assign btb_unused = ^{btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken, BTB_DEPTH[0]};
`endif

  // Lowest asserted index wins; lower-priority sources that cycle are dropped.
  always_comb begin
    redir_any = 1'b0;
    redir_tgt = '0;
    for (int unsigned i = 0; i < NUM_REDIR; i++) begin
      if (redir_valid[i] && !redir_any) begin
        redir_any = 1'b1;
        redir_tgt = redir_pc[i*PC_W +: PC_W];
      end
    end
  end

  assign valid  = (state_q != ST_BOOT);
  assign hs     = valid & fif.fetch_ready;
  assign seq_pc = btb_hit ? btb_tgt : pc_q + PC_W'(INCR);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    unique case (state_q)
      ST_BOOT: begin
        if (redir_any) pc_d = redir_tgt;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (hs) begin
          pc_d = redir_any ? redir_tgt : seq_pc;
        end else if (redir_any) begin
          pend_d  = redir_tgt;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (hs) begin
          pc_d    = redir_any ? redir_tgt : pend_q;
          state_d = ST_RUN;
        end else if (redir_any) begin
          pend_d = redir_tgt;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign fif.fetch_valid   = valid;
  assign fif.fetch_pc      = pc_q;
  assign fif.fetch_stale   = (state_q == ST_PEND);
  assign fif.fetch_adel    = (pc_q[1:0] != 2'b00);
  assign fif.fetch_pred_tk = btb_hit && (state_q == ST_RUN) && !redir_any;

endmodule
